// File: rtl/chip8_arith_sequencer_pkg.sv
// chip8_arith_sequencer_pkg: ALU function codes, opcode fields and sequencer states.
package chip8_arith_sequencer_pkg;
  typedef enum logic [2:0] {
    ALU_f_OR, ALU_f_AND, ALU_f_XOR, ALU_f_ADD, ALU_f_MINUS, ALU_f_RSHIFT, ALU_f_LSHIFT
  } ALU_f;
  localparam logic [3:0] OP_ADDI = 4'h7;
  localparam logic [3:0] OP_ALU  = 4'h8;
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_RD_X  = 3'd1;
  localparam logic [2:0] S_RD_Y  = 3'd2;
  localparam logic [2:0] S_LD_Y  = 3'd3;
  localparam logic [2:0] S_EXEC  = 3'd4;
  localparam logic [2:0] S_WB    = 3'd5;
  localparam logic [2:0] S_WB_VF = 3'd6;
  localparam logic [2:0] S_DONE  = 3'd7;
  function automatic logic is_legal(input logic [15:0] op);
    return op[15:12] == OP_ADDI || (op[15:12] == OP_ALU && (op[3:0] <= 4'h7 || op[3:0] == 4'hE));
  endfunction
  function automatic logic has_flag(input logic [15:0] op);
    return op[15:12] == OP_ALU && (op[3:0] inside {4'h4, 4'h5, 4'h6, 4'h7, 4'hE});
  endfunction
endpackage

// File: rtl/chip8_arith_sequencer.sv
// chip8_arith_sequencer: multi-cycle executor for CHIP-8 7XNN and 8XYN ops.
module chip8_arith_sequencer
  import chip8_arith_sequencer_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] opcode,
  output logic        busy,
  output logic        done,
  output logic        illegal,
  output logic [3:0]  rf_raddr,
  input  logic [7:0]  rf_rdata,
  output logic        rf_we,
  output logic [3:0]  rf_waddr,
  output logic [7:0]  rf_wdata,
  output logic [15:0] alu_input1,
  output logic [15:0] alu_input2,
  output ALU_f        alu_sel,
  input  logic [15:0] alu_out
);
  logic [2:0]  state_q, state_d;
  logic [15:0] op_q, op_d;
  logic [7:0]  vx_q, vx_d, vy_q, vy_d, res_q, res_d;
  logic        flag_q, flag_d, ill_q, ill_d;
  logic [3:0]  x, y, n;
  logic        exec, addi, accept;
  assign x      = op_q[11:8];
  assign y      = op_q[7:4];
  assign n      = op_q[3:0];
  assign exec   = state_q == S_EXEC;
  assign addi   = op_q[15:12] == OP_ADDI;
  assign accept = state_q == S_IDLE && start;
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  state_d = start ? (is_legal(opcode) ? S_RD_X : S_DONE) : S_IDLE;
      S_RD_X:  state_d = S_RD_Y;
      S_RD_Y:  state_d = S_LD_Y;
      S_LD_Y:  state_d = S_EXEC;
      S_EXEC:  state_d = S_WB;
      S_WB:    state_d = has_flag(op_q) ? S_WB_VF : S_DONE;
      S_WB_VF: state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
    op_d   = accept ? opcode : op_q;
    ill_d  = accept ? !is_legal(opcode) : ill_q;
    vx_d   = state_q == S_RD_Y ? rf_rdata : vx_q;
    vy_d   = state_q == S_LD_Y ? rf_rdata : vy_q;
    res_d  = exec ? alu_out[7:0] : res_q;
    flag_d = !exec ? flag_q :
             n == 4'h4 ? alu_out[8] :
             (n == 4'h5 || n == 4'h7) ? alu_out[15:8] == 8'h00 :
             n == 4'h6 ? vx_q[0] : vx_q[7];
  end
  // ALU is only driven during EXEC; idle value is OR of zeros
  always_comb begin
    alu_sel    = !exec ? ALU_f_OR : addi ? ALU_f_ADD :
                 n <= 4'h1 ? ALU_f_OR : n == 4'h2 ? ALU_f_AND : n == 4'h3 ? ALU_f_XOR :
                 n == 4'h4 ? ALU_f_ADD : (n == 4'h5 || n == 4'h7) ? ALU_f_MINUS :
                 n == 4'h6 ? ALU_f_RSHIFT : ALU_f_LSHIFT;
    alu_input1 = !exec ? 16'h0 : addi ? {8'h0, vx_q} : n == 4'h0 ? 16'h0 :
                 n == 4'h7 ? {8'h0, vy_q} : {8'h0, vx_q};
    alu_input2 = !exec ? 16'h0 : addi ? {8'h0, op_q[7:0]} :
                 (n == 4'h6 || n == 4'hE) ? 16'd1 : n == 4'h7 ? {8'h0, vx_q} : {8'h0, vy_q};
  end
  assign busy     = state_q != S_IDLE;
  assign done     = state_q == S_DONE;
  assign illegal  = done && ill_q;
  assign rf_raddr = state_q == S_RD_X ? x : state_q == S_RD_Y ? y : 4'h0;
  assign rf_we    = state_q == S_WB || state_q == S_WB_VF;
  assign rf_waddr = state_q == S_WB ? x : state_q == S_WB_VF ? 4'hF : 4'h0;
  assign rf_wdata = state_q == S_WB ? res_q : state_q == S_WB_VF ? {7'b0, flag_q} : 8'h0;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      vx_q    <= '0;
      vy_q    <= '0;
      res_q   <= '0;
      flag_q  <= 1'b0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      vx_q    <= vx_d;
      vy_q    <= vy_d;
      res_q   <= res_d;
      flag_q  <= flag_d;
      ill_q   <= ill_d;
    end
  end
endmodule

// File: tb/tb_chip8_arith_sequencer.sv
// tb_chip8_arith_sequencer: directed bench with register file / ALU models and a write scoreboard.
module tb_chip8_arith_sequencer;
  import chip8_arith_sequencer_pkg::*;
  logic clk = 0, reset = 1, start = 0;
  logic [15:0] opcode = 0, alu_input1, alu_input2, alu_out;
  logic busy, done, illegal, rf_we;
  logic [3:0] rf_raddr, rf_waddr;
  logic [7:0] rf_rdata, rf_wdata;
  ALU_f alu_sel;
  logic [7:0] rf [16];
  logic pre_we = 0;
  logic [3:0] pre_a = 0;
  logic [7:0] pre_d = 0;
  typedef struct packed {logic [3:0] cyc; logic [3:0] a; logic [7:0] d;} wr_t;
  wr_t q[$];
  int tests = 0, fails = 0;

  chip8_arith_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .opcode(opcode), .busy(busy), .done(done),
    .illegal(illegal), .rf_raddr(rf_raddr), .rf_rdata(rf_rdata), .rf_we(rf_we),
    .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .alu_input1(alu_input1),
    .alu_input2(alu_input2), .alu_sel(alu_sel), .alu_out(alu_out)
  );

  always #5 clk = ~clk;

  always_ff @(posedge clk) begin
    rf_rdata <= rf[rf_raddr];
    if (rf_we) rf[rf_waddr] <= rf_wdata;
    else if (pre_we) rf[pre_a] <= pre_d;
  end

  always_comb begin
    case (alu_sel)
      ALU_f_ADD:    alu_out = alu_input1 + alu_input2;
      ALU_f_MINUS:  alu_out = alu_input1 - alu_input2;
      ALU_f_AND:    alu_out = alu_input1 & alu_input2;
      ALU_f_XOR:    alu_out = alu_input1 ^ alu_input2;
      ALU_f_RSHIFT: alu_out = alu_input1 >> alu_input2;
      ALU_f_LSHIFT: alu_out = alu_input1 << alu_input2;
      default:      alu_out = alu_input1 | alu_input2;
    endcase
  end

  function automatic void chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endfunction

  task automatic set_reg(input logic [3:0] a, input logic [7:0] d);
    @(negedge clk);
    pre_we = 1; pre_a = a; pre_d = d;
    @(negedge clk);
    pre_we = 0;
  endtask

  task automatic push(input logic [3:0] cyc, input logic [3:0] a, input logic [7:0] d);
    q.push_back('{cyc: cyc, a: a, d: d});
  endtask

  task automatic do_op(input string tag, input logic [15:0] op, input int exp_done,
                       input bit exp_ill, input bit pb);
    int k;
    bit got;
    wr_t e;
    k = 0;
    got = 0;
    @(negedge clk);
    start = 1; opcode = op;
    @(negedge clk);
    start = 0;
    while (!got && k < 12) begin
      k++;
      if (k > 1) @(negedge clk);
      if (rf_we) begin
        if (q.size() == 0) chk({tag, "_extra_we"}, {k[3:0], rf_waddr, rf_wdata}, 16'h0);
        else begin
          e = q.pop_front();
          chk({tag, "_wr"}, {k[3:0], rf_waddr, rf_wdata}, e);
        end
      end
      if (done) begin
        got = 1;
        chk({tag, "_done_cyc"}, k, exp_done);
        chk({tag, "_illegal"}, illegal, exp_ill);
      end
      start = pb && k == 2;
      opcode = (pb && k == 2) ? 16'h8128 : op;
    end
    if (!got) chk({tag, "_timeout"}, 0, 1);
    chk({tag, "_pending_wr"}, q.size(), 0);
    q.delete();
    if (pb) begin
      start = 1; opcode = 16'h8128;
      @(negedge clk);
      start = 0;
      chk({tag, "_start_in_done_ignored"}, {busy, done}, 2'b00);
    end
  endtask

  initial begin
    #1;
    chk("reset_outs", {busy, done, illegal, rf_we, rf_raddr, rf_waddr, rf_wdata,
                       alu_input1, alu_input2, alu_sel},
        {4'b0, 4'h0, 4'h0, 8'h0, 16'h0, 16'h0, ALU_f_OR});
    @(negedge clk);
    reset = 0;
    for (int i = 0; i < 16; i++) set_reg(i[3:0], 8'h00);
    set_reg(3, 8'hF0); set_reg(5, 8'h20);
    push(5, 4'h3, 8'h10); push(6, 4'hF, 8'h01);
    do_op("add_carry", 16'h8354, 7, 0, 0);
    set_reg(3, 8'h10);
    push(5, 4'h3, 8'hF0); push(6, 4'hF, 8'h00);
    do_op("sub_borrow", 16'h8355, 7, 0, 0);
    set_reg(3, 8'h20);
    push(5, 4'h3, 8'h00); push(6, 4'hF, 8'h01);
    do_op("sub_equal", 16'h8355, 7, 0, 0);
    set_reg(2, 8'h81);
    push(5, 4'h2, 8'h02); push(6, 4'hF, 8'h01);
    do_op("shl", 16'h820E, 7, 0, 0);
    set_reg(2, 8'h81);
    push(5, 4'h2, 8'h40); push(6, 4'hF, 8'h01);
    do_op("shr", 16'h8206, 7, 0, 0);
    set_reg(4'hA, 8'h02); set_reg(4'hF, 8'h55);
    push(5, 4'hA, 8'h01);
    do_op("addi", 16'h7AFF, 6, 0, 0);
    chk("addi_vf_untouched", rf[15], 8'h55);
    set_reg(4'hF, 8'hFF); set_reg(4'hA, 8'h01);
    push(5, 4'hF, 8'h00); push(6, 4'hF, 8'h01);
    do_op("vf_dest", 16'h8FA4, 7, 0, 0);
    chk("vf_dest_final", rf[15], 8'h01);
    set_reg(1, 8'h10); set_reg(2, 8'h30);
    push(5, 4'h1, 8'h20); push(6, 4'hF, 8'h01);
    do_op("subn", 16'h8127, 7, 0, 0);
    push(5, 4'h1, 8'h30);
    do_op("mov", 16'h8120, 6, 0, 0);
    do_op("illegal", 16'h8128, 1, 1, 0);
    set_reg(1, 8'h0F); set_reg(2, 8'hFF);
    push(5, 4'h1, 8'hF0);
    do_op("xor_busy_start", 16'h8123, 6, 0, 1);
    set_reg(1, 8'h33); set_reg(4'hF, 8'h77);
    @(negedge clk);
    start = 1; opcode = 16'h8124;
    repeat (4) @(negedge clk);
    start = 0;
    reset = 1;
    #1;
    chk("rst_mid_busy_we", {busy, rf_we}, 2'b00);
    repeat (3) begin
      @(negedge clk);
      chk("rst_mid_no_we", rf_we, 1'b0);
    end
    reset = 0;
    @(negedge clk);
    chk("rst_mid_regs", {rf[1], rf[15], busy}, {8'h33, 8'h77, 1'b0});
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/chip8_arith_sequencer.md
# chip8_arith_sequencer

Multi-cycle controller that executes CHIP-8 arithmetic/logic opcodes (8XYN family plus 7XNN) on behalf of the CPU. It reads Vx/Vy from the V register file, drives the shared combinational ALU (Chip8_ALU), and writes the result back to Vx. Where the opcode defines a flag, it then writes VF. It sits between the CPU fetch/decode FSM and the register file/ALU, and handshakes with the CPU via start/done.

## Interface
- No parameters; widths fixed by the CHIP-8 architecture.
- clk  in  1  system clock; all state changes on rising edge
- reset  in  1  asynchronous, active-high; forces IDLE
- start  in  1  one-cycle request; sampled only in IDLE
- opcode  in  16  instruction word, valid with start
- busy  out  1  high whenever state != IDLE
- done  out  1  one-cycle pulse on completion
- illegal  out  1  high with done when opcode not supported
- rf_raddr  out  4  register-file read address (1-cycle read latency)
- rf_rdata  in  8  read data for the address presented the previous cycle
- rf_we  out  1  register-file write strobe
- rf_waddr  out  4  write address
- rf_wdata  out  8  write data
- alu_input1, alu_input2  out  16  zero-extended operands to ALU
- alu_sel  out  ALU_f  ALU function select
- alu_out  in  16  ALU result

## Operation
- States: IDLE, RD_X, RD_Y, LD_Y, EXEC, WB, WB_VF, DONE.
- IDLE & start: latch opcode; X = opcode[11:8], Y = opcode[7:4], N = opcode[3:0], NN = opcode[7:0]; go RD_X.
- Legal: 7XNN; 8XYN with N in {0,1,2,3,4,5,6,7,E}. All others: go straight to DONE with illegal=1, no rf_we.
- RD_X: rf_raddr=X. RD_Y: rf_raddr=Y, capture vx=rf_rdata. LD_Y: capture vy=rf_rdata.
- EXEC: drive ALU, register res=alu_out[7:0] and flag:
  - 7XNN: ADD(vx,NN); no VF write.
  - 8XY0: res=vy (ALU OR with in1=0). 8XY1/2/3: OR/AND/XOR(vx,vy). No VF write.
  - 8XY4: ADD(vx,vy); flag=alu_out[8].
  - 8XY5: MINUS(vx,vy); flag=(alu_out[15:8]==0), i.e. 1 when vx>=vy.
  - 8XY7: MINUS(vy,vx); flag=(alu_out[15:8]==0).
  - 8XY6: RSHIFT(vx,1); flag=vx[0]. 8XYE: LSHIFT(vx,1); flag=vx[7].
- WB: rf_we=1, rf_waddr=X, rf_wdata=res. Next: WB_VF if the op has a flag, else DONE.
- WB_VF: rf_we=1, rf_waddr=4'hF, rf_wdata={7'b0,flag}; next DONE.
- DONE: done=1 (illegal as latched); next IDLE.
- VF written after Vx, so for X=F the flag wins.
- Outside EXEC: alu_input1/2=0, alu_sel=ALU_f_OR.

## Timing
- All outputs are Moore decodes of the registered state/datapath; no combinational path from start or rf_rdata to outputs.
- Reset values: state IDLE; busy, done, illegal, rf_we = 0; rf_raddr, rf_waddr, rf_wdata = 0; ALU inputs 0; opcode/vx/vy/res/flag registers 0.
- start sampled at edge T:
  - Non-flag op: WB at T+5, done at T+6.
  - Flag op: WB at T+5, WB_VF at T+6, done at T+7.
  - Illegal: done at T+1.
- start while busy is ignored, not queued. start in the DONE cycle is ignored; earliest accepted restart is the cycle after done.
- Reset asserted mid-operation: immediate return to IDLE; no further rf_we. A write already completed stays.
- Arithmetic: 8-bit results are truncated from the 16-bit ALU output. Shift amount is always 1.

## Structure
- Sequencer state enum (Seq_state) goes in the shared enums.svh beside ALU_f; opcode field constants (OP_ADDI=4'h7, OP_ALU=4'h8) also go there.
- No sub-module; the ALU is instantiated by the CPU and wired to the alu_* ports.

## Test plan
- V3=8'hF0, V5=8'h20, opcode 8354 -> V3=8'h10, VF=1; done at T+7.
- V3=8'h10, V5=8'h20, opcode 8355 -> V3=8'hF0, VF=0. Repeat with V3=V5=8'h20 -> V3=0, VF=1.
- V2=8'h81, opcode 820E -> V2=8'h02, VF=1; opcode 8206 on V2=8'h81 -> V2=8'h40, VF=1.
- opcode 7AFF with VA=8'h02 -> VA=8'h01, VF untouched, done at T+6; opcode 8FA4 with VF=8'hFF, VA=8'h01 -> VF=1 (flag overwrites sum).
- opcode 8128 -> done+illegal at T+1, no rf_we. start pulsed while busy -> ignored, single done.
- reset asserted during EXEC of 8124 -> busy=0 next cycle, no rf_we, V1/VF unchanged.
